// File: rtl/dpram_arb_pkg.sv
// Shared types and constants for the dual-port RAM arbiter: RAM pin polarity,
// port selection and the per-port read-response tracker.
package dpram_arb_pkg;

    localparam logic RAM_RD = 1'b1;
    localparam logic RAM_WR = 1'b0;

    // Wide enough for the largest supported requester count (16).
    localparam int unsigned ID_W = 4;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tracker_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first index at or after start (with wrap) whose valid bit is
// set and whose exclude bit is clear.
module rr_pick #(
    parameter int unsigned  N  = 4,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] start,
    input  logic [N-1:0]  exclude,
    output logic          found,
    output logic [PW-1:0] idx
);

    logic [PW-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest candidate wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            pos = PW'((int'(start) + k) % int'(N));
            if (valid[pos] && !exclude[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM among NUM_REQ requesters, up to two
// grants per cycle. Define DPRAM_ARB_RESP_REG_EN to add a response register stage.
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ    = 4,
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  DEPTH      = 1024,
    localparam int unsigned AW         = $clog2(DEPTH),
    localparam int unsigned PW         = $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*AW-1:0]         req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] resp_data,
    output logic                          ram_en_a,
    output logic                          ram_en_b,
    output logic                          ram_wr_a,
    output logic                          ram_wr_b,
    output logic [AW-1:0]                 ram_addr_a,
    output logic [AW-1:0]                 ram_addr_b,
    output logic [DATA_WIDTH-1:0]         ram_wdata_a,
    output logic [DATA_WIDTH-1:0]         ram_wdata_b,
    input  logic [DATA_WIDTH-1:0]         ram_rdata_a,
    input  logic [DATA_WIDTH-1:0]         ram_rdata_b
);

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    logic [PW-1:0]           ptr_q, ptr_d;
    tracker_t                trk_q [2];
    tracker_t                trk_d [2];
    logic                    found_a, found_b, grant_a, grant_b, conflict;
    logic [PW-1:0]           idx_a, idx_b, start_b;
    logic [NUM_REQ-1:0]      excl_b;
    logic [AW-1:0]           addr_a, addr_b;
    logic [DATA_WIDTH-1:0]   wdata_a, wdata_b;
    logic [NUM_REQ-1:0]      resp_valid_c;
    logic [NUM_REQ*DATA_WIDTH-1:0] resp_data_c;

    rr_pick #(.N(NUM_REQ)) u_pick_a (
        .valid   (req_valid),
        .start   (ptr_q),
        .exclude ('0),
        .found   (found_a),
        .idx     (idx_a)
    );

    assign start_b = wrap_inc(idx_a);
    assign excl_b  = NUM_REQ'(1) << idx_a;

    rr_pick #(.N(NUM_REQ)) u_pick_b (
        .valid   (req_valid),
        .start   (start_b),
        .exclude (excl_b),
        .found   (found_b),
        .idx     (idx_b)
    );

    always_comb begin
        addr_a   = req_addr[idx_a*AW +: AW];
        addr_b   = req_addr[idx_b*AW +: AW];
        wdata_a  = req_wdata[idx_a*DATA_WIDTH +: DATA_WIDTH];
        wdata_b  = req_wdata[idx_b*DATA_WIDTH +: DATA_WIDTH];
        // Two writes to one word cannot both land; the second pick retries.
        conflict = found_b && req_write[idx_a] && req_write[idx_b] && (addr_a == addr_b);
        grant_a  = found_a && !reset;
        grant_b  = found_b && !conflict && !reset;
    end

    always_comb begin
        req_ready = '0;
        if (grant_a) req_ready[idx_a] = 1'b1;
        if (grant_b) req_ready[idx_b] = 1'b1;
        ram_en_a    = grant_a;
        ram_en_b    = grant_b;
        ram_wr_a    = (grant_a && req_write[idx_a]) ? RAM_WR : RAM_RD;
        ram_wr_b    = (grant_b && req_write[idx_b]) ? RAM_WR : RAM_RD;
        ram_addr_a  = grant_a ? addr_a : '0;
        ram_addr_b  = grant_b ? addr_b : '0;
        ram_wdata_a = grant_a ? wdata_a : '0;
        ram_wdata_b = grant_b ? wdata_b : '0;
    end

    always_comb begin
        trk_d[PORT_A] = '{vld: grant_a && !req_write[idx_a], id: ID_W'(idx_a)};
        trk_d[PORT_B] = '{vld: grant_b && !req_write[idx_b], id: ID_W'(idx_b)};
        if (grant_b)      ptr_d = wrap_inc(idx_b);
        else if (grant_a) ptr_d = wrap_inc(idx_a);
        else              ptr_d = ptr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q         <= '0;
            trk_q[PORT_A] <= '0;
            trk_q[PORT_B] <= '0;
        end else begin
            ptr_q         <= ptr_d;
            trk_q[PORT_A] <= trk_d[PORT_A];
            trk_q[PORT_B] <= trk_d[PORT_B];
        end
    end

    // Reset discards any response still in flight from the previous cycle's read.
    always_comb begin
        resp_valid_c = '0;
        resp_data_c  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!reset && trk_q[PORT_A].vld && (32'(trk_q[PORT_A].id) == i)) begin
                resp_valid_c[i]                         = 1'b1;
                resp_data_c[i*DATA_WIDTH +: DATA_WIDTH] = ram_rdata_a;
            end
            if (!reset && trk_q[PORT_B].vld && (32'(trk_q[PORT_B].id) == i)) begin
                resp_valid_c[i]                         = 1'b1;
                resp_data_c[i*DATA_WIDTH +: DATA_WIDTH] = ram_rdata_b;
            end
        end
    end

`ifdef DPRAM_ARB_RESP_REG_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= resp_valid_c;
            resp_data  <= resp_data_c;
        end
    end
`else
    assign resp_valid = resp_valid_c;
    assign resp_data  = resp_data_c;
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural registered-read dual-port RAM.
module tb_dpram_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 10;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid, req_write, req_ready, resp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata, resp_data;
    logic              ram_en_a, ram_en_b, ram_wr_a, ram_wr_b;
    logic [AW-1:0]     ram_addr_a, ram_addr_b;
    logic [DW-1:0]     ram_wdata_a, ram_wdata_b;
    logic [DW-1:0]     ram_rdata_a = '0;
    logic [DW-1:0]     ram_rdata_b = '0;
    logic [DW-1:0]     mem [1024];
    int                n_vec = 0;
    int                n_err = 0;
    int                cnt [N];

    always #5 clock = ~clock;

    dpram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(1024)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .ram_en_a    (ram_en_a),
        .ram_en_b    (ram_en_b),
        .ram_wr_a    (ram_wr_a),
        .ram_wr_b    (ram_wr_b),
        .ram_addr_a  (ram_addr_a),
        .ram_addr_b  (ram_addr_b),
        .ram_wdata_a (ram_wdata_a),
        .ram_wdata_b (ram_wdata_b),
        .ram_rdata_a (ram_rdata_a),
        .ram_rdata_b (ram_rdata_b)
    );

    // RAM macro: rd=1, registered read data (zero when not reading), read-before-write.
    always @(posedge clock) begin
        ram_rdata_a <= (ram_en_a && ram_wr_a) ? mem[ram_addr_a] : '0;
        ram_rdata_b <= (ram_en_b && ram_wr_b) ? mem[ram_addr_b] : '0;
        if (ram_en_a && !ram_wr_a) mem[ram_addr_a] <= ram_wdata_a;
        if (ram_en_b && !ram_wr_b) mem[ram_addr_b] <= ram_wdata_b;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic resp_wait();
`ifdef DPRAM_ARB_RESP_REG_EN
        tick();
`endif
    endtask

    task automatic clr();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i]           = 1'b1;
        req_write[i]           = w;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with every requester asking: nothing may be granted.
        clr();
        req_valid = '1;
        #3;
        chk("rst_ready", 128'(req_ready), 128'h0);
        chk("rst_en", 128'({ram_en_a, ram_en_b}), 128'h0);
        tick();
        tick();
        chk("rst_resp", 128'(resp_valid), 128'h0);
        reset = 1'b0;
        clr();
        #1;
        chk("idle_pins", 128'({ram_en_a, ram_wr_a, ram_addr_a, ram_wdata_a}), 128'h1 << 42);

        // Preload ram[5] = A5 through requester 0 (ptr 0 -> 1).
        set_req(0, 1'b1, 10'd5, 32'hA5);
        #1;
        chk("wr5_ready", 128'(req_ready), 128'h1);
        chk("wr5_pins", 128'({ram_en_a, ram_wr_a, ram_addr_a, ram_wdata_a, ram_en_b}),
            128'({1'b1, 1'b0, 10'd5, 32'hA5, 1'b0}));
        tick();
        clr();

        // Single read of addr 5 by requester 0 (ptr 1 wraps to 0).
        set_req(0, 1'b0, 10'd5, 32'h0);
        #1;
        chk("rd5_ready", 128'(req_ready), 128'h1);
        chk("rd5_pins", 128'({ram_en_a, ram_wr_a, ram_addr_a}), 128'({1'b1, 1'b1, 10'd5}));
        tick();
        clr();
        resp_wait();
        chk("rd5_rvalid", 128'(resp_valid), 128'h1);
        chk("rd5_rdata", 128'(resp_data), 128'hA5);
        tick();
        chk("rd5_rvalid_drop", 128'(resp_valid), 128'h0);

        // Requester 3 write moves ptr to 0.
        set_req(3, 1'b1, 10'd100, 32'h0);
        tick();
        clr();

        // Dual grant: 1 on port A, 2 on port B; ptr -> 3.
        set_req(1, 1'b1, 10'd3, 32'h11);
        set_req(2, 1'b1, 10'd4, 32'h22);
        #1;
        chk("dual_ready", 128'(req_ready), 128'h6);
        chk("dual_pins", 128'({ram_wr_a, ram_addr_a, ram_wdata_a, ram_wr_b, ram_addr_b,
                               ram_wdata_b}),
            128'({1'b0, 10'd3, 32'h11, 1'b0, 10'd4, 32'h22}));
        tick();
        clr();

        // With ptr 3: requester 3 on A (addr 4), 2 on B (addr 3).
        set_req(2, 1'b0, 10'd3, 32'h0);
        set_req(3, 1'b0, 10'd4, 32'h0);
        #1;
        chk("ptr3_addrs", 128'({ram_addr_a, ram_addr_b}), 128'({10'd4, 10'd3}));
        tick();
        clr();
        resp_wait();
        chk("dual_rvalid", 128'(resp_valid), 128'hC);
        chk("dual_rdata", 128'(resp_data), {32'h22, 32'h11, 64'h0});

        // Write conflict on addr 7 (ptr 3 -> picks 0 then 1).
        set_req(0, 1'b1, 10'd7, 32'hAA);
        set_req(1, 1'b1, 10'd7, 32'hBB);
        #1;
        chk("conf_c1_ready", 128'(req_ready), 128'h1);
        chk("conf_c1_enb", 128'(ram_en_b), 128'h0);
        tick();
        req_valid[0] = 1'b0;
        #1;
        chk("conf_c2_ready", 128'(req_ready), 128'h2);
        chk("conf_c2_wdata", 128'(ram_wdata_a), 128'hBB);
        tick();
        clr();
        set_req(0, 1'b0, 10'd7, 32'h0);
        tick();
        clr();
        resp_wait();
        chk("conf_rdata", 128'(resp_data), 128'hBB);

        // Requester 3 write moves ptr back to 0 for the fairness run.
        set_req(3, 1'b1, 10'd200, 32'h0);
        tick();
        clr();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 10'(20 + i), 32'(i));
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("fair_c%0d", c), 128'(req_ready), (c % 2 == 0) ? 128'h3 : 128'hC);
            for (int i = 0; i < N; i++) if (req_ready[i]) cnt[i]++;
            tick();
        end
        clr();
        for (int i = 0; i < N; i++) chk($sformatf("fair_cnt%0d", i), 128'(cnt[i]), 128'd4);

        // Read and write to addr 9 in one cycle: read sees the old value.
        set_req(0, 1'b1, 10'd9, 32'h1);
        tick();
        clr();
        set_req(0, 1'b1, 10'd9, 32'h2);
        set_req(1, 1'b0, 10'd9, 32'h0);
        #1;
        chk("rw_ready", 128'(req_ready), 128'h3);
        chk("rw_wr", 128'({ram_wr_a, ram_wr_b}), 128'b10);
        tick();
        clr();
        resp_wait();
        chk("rw_old", 128'(resp_data), 128'h1 << 32);
        set_req(1, 1'b0, 10'd9, 32'h0);
        tick();
        clr();
        resp_wait();
        chk("rw_new", 128'(resp_data), 128'h2 << 32);

        // Reset while a read is in flight (ptr 2 -> requester 2 on A).
        set_req(2, 1'b0, 10'd9, 32'h0);
        #1;
        chk("rr_ready", 128'(req_ready), 128'h4);
        tick();
        clr();
        reset = 1'b1;
        #1;
        chk("rr_rvalid_t1", 128'(resp_valid), 128'h0);
        tick();
        chk("rr_rvalid_t2", 128'(resp_valid), 128'h0);
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 10'(40 + i), 32'h0);
        #1;
        chk("rr_ptr0", 128'(req_ready), 128'h3);
        tick();
        clr();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
